// File: rtl/imm_share_arbiter.sv
// Two-requester arbiter that time-shares the immediate selector between decode (r0)
// and the early branch-target unit (r1), holding each result in a per-requester slot.
module imm_share_arbiter #(
    parameter int PRIO_FIXED = 0,
    localparam int unsigned EXT_W  = 11,
    localparam int unsigned SEL_W  = 3,
    localparam int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic [EXT_W-1:0]  r0_extend,
    input  logic [SEL_W-1:0]  r0_sel,
    input  logic [DATA_W-1:0] r0_pc2,
    output logic              r0_gnt,
    output logic              r0_valid,
    output logic [DATA_W-1:0] r0_imm,
    output logic              r0_err,
    input  logic              r0_ack,

    input  logic              r1_req,
    input  logic [EXT_W-1:0]  r1_extend,
    input  logic [SEL_W-1:0]  r1_sel,
    input  logic [DATA_W-1:0] r1_pc2,
    output logic              r1_gnt,
    output logic              r1_valid,
    output logic [DATA_W-1:0] r1_imm,
    output logic              r1_err,
    input  logic              r1_ack,

    output logic [EXT_W-1:0]  Extend,
    output logic [SEL_W-1:0]  Imm_Sel,
    output logic [DATA_W-1:0] PC2,
    input  logic [DATA_W-1:0] Immediate
);

    localparam logic              FIXED       = (PRIO_FIXED != 0);
    localparam logic [SEL_W-1:0]  SEL_ILLEGAL = SEL_W'(5);

    logic              r0_valid_q, r0_valid_d;
    logic [DATA_W-1:0] r0_imm_q,   r0_imm_d;
    logic              r0_err_q,   r0_err_d;
    logic              r1_valid_q, r1_valid_d;
    logic [DATA_W-1:0] r1_imm_q,   r1_imm_d;
    logic              r1_err_q,   r1_err_d;
    logic              last_q,     last_d;
    logic              elig0, elig1;

    // A slot can take a result when empty or being drained this cycle.
    always_comb begin
        elig0  = r0_req & (~r0_valid_q | r0_ack);
        elig1  = r1_req & (~r1_valid_q | r1_ack);
        r0_gnt = ~rst & elig0 & (~elig1 | FIXED | last_q);
        r1_gnt = ~rst & elig1 & ~(elig0 & (~elig1 | FIXED | last_q));
    end

    always_comb begin
        Extend  = '0;
        Imm_Sel = '0;
        PC2     = '0;
        if (r0_gnt) begin
            Extend  = r0_extend;
            Imm_Sel = r0_sel;
            PC2     = r0_pc2;
        end else if (r1_gnt) begin
            Extend  = r1_extend;
            Imm_Sel = r1_sel;
            PC2     = r1_pc2;
        end
    end

    // A grant overrides a same-cycle ack so a slot can refill back to back.
    always_comb begin
        r0_valid_d = r0_valid_q;
        r0_imm_d   = r0_imm_q;
        r0_err_d   = r0_err_q;
        r1_valid_d = r1_valid_q;
        r1_imm_d   = r1_imm_q;
        r1_err_d   = r1_err_q;
        last_d     = last_q;

        if (r0_gnt) begin
            r0_valid_d = 1'b1;
            r0_imm_d   = Immediate;
            r0_err_d   = (r0_sel >= SEL_ILLEGAL);
        end else if (r0_ack) begin
            r0_valid_d = 1'b0;
        end

        if (r1_gnt) begin
            r1_valid_d = 1'b1;
            r1_imm_d   = Immediate;
            r1_err_d   = (r1_sel >= SEL_ILLEGAL);
        end else if (r1_ack) begin
            r1_valid_d = 1'b0;
        end

        if (r0_gnt) begin
            last_d = 1'b0;
        end else if (r1_gnt) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid_q <= 1'b0;
            r0_imm_q   <= '0;
            r0_err_q   <= 1'b0;
            r1_valid_q <= 1'b0;
            r1_imm_q   <= '0;
            r1_err_q   <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            r0_valid_q <= r0_valid_d;
            r0_imm_q   <= r0_imm_d;
            r0_err_q   <= r0_err_d;
            r1_valid_q <= r1_valid_d;
            r1_imm_q   <= r1_imm_d;
            r1_err_q   <= r1_err_d;
            last_q     <= last_d;
        end
    end

    assign r0_valid = r0_valid_q;
    assign r0_imm   = r0_imm_q;
    assign r0_err   = r0_err_q;
    assign r1_valid = r1_valid_q;
    assign r1_imm   = r1_imm_q;
    assign r1_err   = r1_err_q;

endmodule

// File: tb/tb_imm_share_arbiter.sv
// Bench for imm_share_arbiter: round-robin (p=0) and fixed-priority (p=1) instances
// share stimulus; a selector model closes the loop and a slot-level model checks both.
module tb_imm_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req [2];
    logic        ack [2];
    logic [10:0] ext [2];
    logic [2:0]  sel [2];
    logic [15:0] pc2 [2];

    logic [1:0]  gnt [2];
    logic [1:0]  vld [2];
    logic [1:0]  err [2];
    logic [15:0] imm [2][2];
    logic [10:0] s_ext [2];
    logic [2:0]  s_sel [2];
    logic [15:0] s_pc [2];
    logic [15:0] s_imm [2];

    int total = 0;
    int bad   = 0;

    // Reference immediate selector/extender.
    function automatic logic [15:0] sel_fn(input logic [2:0] s, input logic [10:0] e,
                                           input logic [15:0] pc);
        case (s)
            3'd0:    return {{11{e[4]}}, e[4:0]};
            3'd1:    return {11'b0, e[4:0]};
            3'd2:    return {{8{e[7]}}, e[7:0]};
            3'd3:    return {{5{e[10]}}, e};
            3'd4:    return pc;
            default: return 16'h0000;
        endcase
    endfunction

    for (genvar p = 0; p < 2; p++) begin : g_dut
        assign s_imm[p] = sel_fn(s_sel[p], s_ext[p], s_pc[p]);
        imm_share_arbiter #(.PRIO_FIXED(p)) u_dut (
            .clk(clk), .rst(rst),
            .r0_req(req[0]), .r0_extend(ext[0]), .r0_sel(sel[0]), .r0_pc2(pc2[0]),
            .r0_gnt(gnt[p][0]), .r0_valid(vld[p][0]), .r0_imm(imm[p][0]),
            .r0_err(err[p][0]), .r0_ack(ack[0]),
            .r1_req(req[1]), .r1_extend(ext[1]), .r1_sel(sel[1]), .r1_pc2(pc2[1]),
            .r1_gnt(gnt[p][1]), .r1_valid(vld[p][1]), .r1_imm(imm[p][1]),
            .r1_err(err[p][1]), .r1_ack(ack[1]),
            .Extend(s_ext[p]), .Imm_Sel(s_sel[p]), .PC2(s_pc[p]), .Immediate(s_imm[p])
        );
    end

    // Model state per instance p and requester r.
    logic        mv [2][2];
    logic [15:0] mi [2][2];
    logic        me [2][2];
    logic        ml [2];

    typedef struct {
        logic        rst;
        logic [1:0]  req, ack;
        logic [2:0]  s0;
        logic [10:0] e0;
        logic [2:0]  s1;
        logic [10:0] e1;
        logic [15:0] p1;
        logic [1:0]  g, v;
        logic [15:0] i0, i1;
        logic [1:0]  er;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One clock: check combinational grant/drive, clock, then check slots.
    task automatic step(input logic has_exp, input vec_t v);
        int   w [2];
        logic el0, el1;
        #1;
        for (int p = 0; p < 2; p++) begin
            el0 = req[0] && (!mv[p][0] || ack[0]);
            el1 = req[1] && (!mv[p][1] || ack[1]);
            if (rst)             w[p] = -1;
            else if (el0 && el1) w[p] = (p == 1) ? 0 : (ml[p] ? 0 : 1);
            else if (el0)        w[p] = 0;
            else if (el1)        w[p] = 1;
            else                 w[p] = -1;
            chk($sformatf("p%0d_gnt", p), 32'(gnt[p]), 32'({w[p] == 1, w[p] == 0}));
            chk($sformatf("p%0d_drive", p), 32'({s_sel[p], s_ext[p], s_pc[p]}),
                (w[p] < 0) ? 32'd0 : 32'({sel[w[p]], ext[w[p]], pc2[w[p]]}));
        end
        if (has_exp) chk("tbl_gnt", 32'(gnt[0]), 32'(v.g));
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                for (int r = 0; r < 2; r++) begin
                    mv[p][r] = 1'b0; mi[p][r] = 16'h0; me[p][r] = 1'b0;
                end
                ml[p] = 1'b1;
            end else begin
                for (int r = 0; r < 2; r++) begin
                    if (w[p] == r) begin
                        mv[p][r] = 1'b1;
                        mi[p][r] = sel_fn(sel[r], ext[r], pc2[r]);
                        me[p][r] = (sel[r] >= 3'd5);
                    end else if (ack[r]) begin
                        mv[p][r] = 1'b0;
                    end
                end
                if (w[p] >= 0) ml[p] = (w[p] == 1);
            end
        end
        @(negedge clk);
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 2; r++)
                chk($sformatf("p%0d_r%0d_slot", p, r), {15'd0, vld[p][r], imm[p][r]},
                    {15'd0, me[p][r] ? 1'b1 : 1'b0, 16'h0} ^ {15'd0, mv[p][r], mi[p][r]}
                    ^ {15'd0, me[p][r] ? 1'b1 : 1'b0, 16'h0});
        for (int p = 0; p < 2; p++)
            chk($sformatf("p%0d_err", p), 32'(err[p]), 32'({me[p][1], me[p][0]}));
        if (has_exp) begin
            chk("tbl_valid", 32'(vld[0]), 32'(v.v));
            chk("tbl_imm0", 32'(imm[0][0]), 32'(v.i0));
            chk("tbl_imm1", 32'(imm[0][1]), 32'(v.i1));
            chk("tbl_err", 32'(err[0]), 32'(v.er));
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst;
        req[0] = v.req[0]; req[1] = v.req[1];
        ack[0] = v.ack[0]; ack[1] = v.ack[1];
        sel[0] = v.s0; ext[0] = v.e0; pc2[0] = 16'h0100;
        sel[1] = v.s1; ext[1] = v.e1; pc2[1] = v.p1;
    endtask

    initial begin
        vec_t none;
        none = '{1'b0, 2'b00, 2'b00, 3'd0, 11'h0, 3'd0, 11'h0, 16'h0,
                 2'b00, 2'b00, 16'h0, 16'h0, 2'b00};
        //          rst req    ack    s0    e0       s1    e1       p1        g      v      i0        i1        er
        tbl[0]  = '{1'b1, 2'b11, 2'b00, 3'd0, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00};
        tbl[1]  = '{1'b1, 2'b11, 2'b00, 3'd0, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00};
        tbl[2]  = '{1'b0, 2'b11, 2'b00, 3'd0, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b01, 2'b01, 16'hFFFF, 16'h0000, 2'b00};
        tbl[3]  = '{1'b0, 2'b11, 2'b01, 3'd0, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b10, 2'b10, 16'hFFFF, 16'h1234, 2'b00};
        tbl[4]  = '{1'b0, 2'b11, 2'b11, 3'd0, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b01, 2'b01, 16'hFFFF, 16'h1234, 2'b00};
        tbl[5]  = '{1'b0, 2'b11, 2'b11, 3'd0, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b10, 2'b10, 16'hFFFF, 16'h1234, 2'b00};
        tbl[6]  = '{1'b0, 2'b01, 2'b00, 3'd1, 11'h01F, 3'd4, 11'h000, 16'h1234, 2'b01, 2'b11, 16'h001F, 16'h1234, 2'b00};
        tbl[7]  = '{1'b0, 2'b11, 2'b10, 3'd1, 11'h01F, 3'd4, 11'h000, 16'h5678, 2'b10, 2'b11, 16'h001F, 16'h5678, 2'b00};
        tbl[8]  = '{1'b0, 2'b11, 2'b01, 3'd2, 11'h080, 3'd4, 11'h000, 16'h5678, 2'b01, 2'b11, 16'hFF80, 16'h5678, 2'b00};
        tbl[9]  = '{1'b0, 2'b10, 2'b10, 3'd2, 11'h080, 3'd6, 11'h000, 16'h5678, 2'b10, 2'b11, 16'hFF80, 16'h0000, 2'b10};
        tbl[10] = '{1'b0, 2'b10, 2'b10, 3'd2, 11'h080, 3'd2, 11'h080, 16'h5678, 2'b10, 2'b11, 16'hFF80, 16'hFF80, 2'b00};
        tbl[11] = '{1'b1, 2'b11, 2'b00, 3'd2, 11'h080, 3'd2, 11'h080, 16'h5678, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00};
        tbl[12] = '{1'b0, 2'b00, 2'b01, 3'd0, 11'h01F, 3'd2, 11'h080, 16'h5678, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00};
        tbl[13] = '{1'b0, 2'b01, 2'b00, 3'd0, 11'h01F, 3'd2, 11'h080, 16'h5678, 2'b01, 2'b01, 16'hFFFF, 16'h0000, 2'b00};

        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 2; r++) begin
                mv[p][r] = 1'b0; mi[p][r] = 16'h0; me[p][r] = 1'b0;
            end
            ml[p] = 1'b1;
        end
        apply(tbl[0]);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i]);
            step(1'b1, tbl[i]);
        end

        // Fixed priority: after reset, r0 wins every cycle while both request and ack.
        apply(tbl[0]);
        step(1'b0, none);
        rst = 1'b0; ack[0] = 1'b1; ack[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, none);
            chk("fixed_r0_only", 32'(gnt[1]), 32'(2'b01));
        end

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            for (int r = 0; r < 2; r++) begin
                req[r] = 1'($urandom);
                ack[r] = 1'($urandom);
                sel[r] = 3'($urandom_range(0, 7));
                ext[r] = 11'($urandom);
                pc2[r] = 16'($urandom);
            end
            step(1'b0, none);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
